// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared register-file types and sizes
package cpu_types_pkg;
    localparam int NUM_REGS = 32;
    localparam int WORD_W = 32;

    typedef logic [4:0]        regbits_t;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/regfile_scoreboard_decoder.sv
// rtl/regfile_scoreboard_decoder.sv - 5-to-32 one-hot write-enable decoder
module regfile_scoreboard_decoder
    import cpu_types_pkg::*;
(
    input  logic                en,
    input  regbits_t            sel,
    output logic [NUM_REGS-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32-entry writeback register file with per-register pending-write scoreboard
module regfile_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int DW     = 32,
    parameter int PEND_W = 2,
    parameter int BYPASS = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WEN,
    input  regbits_t      wsel,
    input  logic [DW-1:0] wdat,
    input  regbits_t      rsel1,
    input  regbits_t      rsel2,
    output logic [DW-1:0] rdat1,
    output logic [DW-1:0] rdat2,
    output logic          busy1,
    output logic          busy2,
    input  logic          issue_valid,
    input  regbits_t      issue_rd,
    output logic          issue_ready
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [DW-1:0]       regs [NUM_REGS];
    logic [PEND_W-1:0]   pend [NUM_REGS];
    logic [NUM_REGS-1:0] dec_en;
    logic [NUM_REGS-1:0] en;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;

    regfile_scoreboard_decoder u_decoder (
        .en     (WEN),
        .sel    (wsel),
        .onehot (dec_en)
    );

    // Register 0 is hardwired to zero, so its enable is stripped here.
    assign en = dec_en & ~NUM_REGS'(1);

    // A retiring write cannot free a slot for the same-cycle issue: ready looks at pend only.
    assign issue_ready = !(issue_valid && (issue_rd != '0) && (pend[issue_rd] == PEND_MAX));

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        assign inc[r] = issue_valid && issue_ready && (issue_rd == regbits_t'(r)) && (r != 0);
        assign dec[r] = en[r] && (pend[r] != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (en[i]) begin
                    regs[i] <= wdat;
                end
                pend[i] <= pend[i] + PEND_W'(inc[i]) - PEND_W'(dec[i]);
            end
        end
    end

    // Busy discounts a write retiring this cycle, so the last write clears busy immediately.
    always_comb begin
        rdat1 = '0;
        busy1 = 1'b0;
        if (rsel1 != '0) begin
            rdat1 = ((BYPASS != 0) && WEN && (wsel == rsel1)) ? wdat : regs[rsel1];
            busy1 = (pend[rsel1] - PEND_W'(dec[rsel1])) != '0;
        end
    end

    always_comb begin
        rdat2 = '0;
        busy2 = 1'b0;
        if (rsel2 != '0) begin
            rdat2 = ((BYPASS != 0) && WEN && (wsel == rsel2)) ? wdat : regs[rsel2];
            busy2 = (pend[rsel2] - PEND_W'(dec[rsel2])) != '0;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed vector table plus randomized model check for regfile_scoreboard
module tb_regfile_scoreboard;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     RST, WEN, issue_valid;
    regbits_t wsel, rsel1, rsel2, issue_rd;
    word_t    wdat, rdat1, rdat2;
    logic     busy1, busy2, issue_ready;

    int total = 0;
    int bad = 0;

    int model_regs [32];
    int model_pend [32];

    typedef struct {
        logic     rst;
        logic     wen;
        regbits_t wsel;
        word_t    wdat;
        regbits_t rs1;
        regbits_t rs2;
        logic     iv;
        regbits_t ird;
        logic     chk;
        word_t    e_r1;
        word_t    e_r2;
        logic     e_b1;
        logic     e_b2;
        logic     e_rdy;
    } vec_t;

    vec_t vecs[$];

    regfile_scoreboard #(.DW(32), .PEND_W(2), .BYPASS(1)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WEN         (WEN),
        .wsel        (wsel),
        .wdat        (wdat),
        .rsel1       (rsel1),
        .rsel2       (rsel2),
        .rdat1       (rdat1),
        .rdat2       (rdat2),
        .busy1       (busy1),
        .busy2       (busy2),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready)
    );

    always #5 CLK = ~CLK;

    function automatic void add(logic rst, logic wen, int ws, word_t wd, int r1, int r2,
                                logic iv, int ird, logic chk, word_t e1, word_t e2,
                                logic b1, logic b2, logic rdy);
        vec_t v;
        v.rst = rst; v.wen = wen; v.wsel = regbits_t'(ws); v.wdat = wd;
        v.rs1 = regbits_t'(r1); v.rs2 = regbits_t'(r2); v.iv = iv; v.ird = regbits_t'(ird);
        v.chk = chk; v.e_r1 = e1; v.e_r2 = e2; v.e_b1 = b1; v.e_b2 = b2; v.e_rdy = rdy;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Reference rules applied once per clock edge with the values that were driven.
    task automatic model_update(logic rst, logic wen, int ws, word_t wd, logic iv, int ird);
        bit rdy, inc, dec;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                model_regs[i] = 0;
                model_pend[i] = 0;
            end
        end else begin
            rdy = !(iv && ird != 0 && model_pend[ird] == 3);
            inc = iv && rdy && ird != 0;
            dec = wen && ws != 0 && model_pend[ws] > 0;
            if (wen && ws != 0) model_regs[ws] = int'(wd);
            if (inc) model_pend[ird] = model_pend[ird] + 1;
            if (dec) model_pend[ws] = model_pend[ws] - 1;
        end
    endtask

    task automatic drive(logic rst, logic wen, regbits_t ws, word_t wd, regbits_t r1, regbits_t r2,
                         logic iv, regbits_t ird);
        RST = rst; WEN = wen; wsel = ws; wdat = wd;
        rsel1 = r1; rsel2 = r2; issue_valid = iv; issue_rd = ird;
    endtask

    task automatic tick(logic rst, logic wen, int ws, word_t wd, logic iv, int ird);
        @(posedge CLK);
        #1;
        model_update(rst, wen, ws, wd, iv, ird);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 32; i++) begin
            model_regs[i] = 0;
            model_pend[i] = 0;
        end

        //   rst wen ws wdat          r1  r2  iv ird chk e_r1          e_r2        b1 b2 rdy
        add(1, 1, 5, 32'hDEADBEEF,  5,  0, 0, 0,  0, 32'h0,        32'h0,       0, 0, 1);
        add(1, 1, 5, 32'hDEADBEEF,  5,  0, 0, 0,  1, 32'hDEADBEEF, 32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         5,  0, 0, 0,  1, 32'h0,        32'h0,       0, 0, 1);
        add(0, 1, 7, 32'h12345678,  7,  0, 0, 0,  1, 32'h12345678, 32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         7,  0, 0, 0,  1, 32'h12345678, 32'h0,       0, 0, 1);
        add(0, 1, 0, 32'hFFFFFFFF,  0,  0, 1, 0,  1, 32'h0,        32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         0,  0, 1, 0,  1, 32'h0,        32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         3,  0, 1, 3,  1, 32'h0,        32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         3,  0, 1, 3,  1, 32'h0,        32'h0,       1, 0, 1);
        add(0, 0, 0, 32'h0,         3,  0, 1, 3,  1, 32'h0,        32'h0,       1, 0, 1);
        add(0, 0, 0, 32'h0,         3,  0, 1, 3,  1, 32'h0,        32'h0,       1, 0, 0);
        add(0, 0, 0, 32'h0,         3,  0, 1, 3,  1, 32'h0,        32'h0,       1, 0, 0);
        add(0, 1, 3, 32'h33,        3,  0, 1, 3,  1, 32'h33,       32'h0,       1, 0, 0);
        add(0, 1, 3, 32'h34,        3,  0, 0, 0,  1, 32'h34,       32'h0,       1, 0, 1);
        add(0, 1, 3, 32'h35,        3,  0, 0, 0,  1, 32'h35,       32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         3,  0, 0, 0,  1, 32'h35,       32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         9,  0, 1, 9,  1, 32'h0,        32'h0,       0, 0, 1);
        add(0, 1, 9, 32'hA5,        9,  0, 1, 9,  1, 32'hA5,       32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         9,  0, 0, 0,  1, 32'hA5,       32'h0,       1, 0, 1);
        add(0, 1, 12, 32'hC0FFEE,  12, 12, 0, 0,  1, 32'hC0FFEE,   32'hC0FFEE,  0, 0, 1);
        add(0, 0, 0, 32'h0,        12,  0, 0, 0,  1, 32'hC0FFEE,   32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,        12,  0, 1, 12, 1, 32'hC0FFEE,   32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,        12,  0, 0, 0,  1, 32'hC0FFEE,   32'h0,       1, 0, 1);
        add(0, 1, 12, 32'h1,       12,  0, 0, 0,  1, 32'h1,        32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,        12,  0, 0, 0,  1, 32'h1,        32'h0,       0, 0, 1);
        add(0, 1, 4, 32'h44,        4,  0, 0, 0,  1, 32'h44,       32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         4,  0, 1, 4,  1, 32'h44,       32'h0,       0, 0, 1);
        add(0, 0, 0, 32'h0,         4,  0, 1, 4,  1, 32'h44,       32'h0,       1, 0, 1);
        add(1, 0, 0, 32'h0,         4,  0, 0, 0,  1, 32'h44,       32'h0,       1, 0, 1);
        add(0, 0, 0, 32'h0,         4,  4, 0, 0,  1, 32'h0,        32'h0,       0, 0, 1);

        @(posedge CLK);
        #1;
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].wen, vecs[k].wsel, vecs[k].wdat,
                  vecs[k].rs1, vecs[k].rs2, vecs[k].iv, vecs[k].ird);
            #3;
            if (vecs[k].chk) begin
                check("rdat1", k, rdat1, vecs[k].e_r1);
                check("rdat2", k, rdat2, vecs[k].e_r2);
                check("busy1", k, 32'(busy1), 32'(vecs[k].e_b1));
                check("busy2", k, 32'(busy2), 32'(vecs[k].e_b2));
                check("issue_ready", k, 32'(issue_ready), 32'(vecs[k].e_rdy));
            end
            tick(vecs[k].rst, vecs[k].wen, int'(vecs[k].wsel), vecs[k].wdat,
                 vecs[k].iv, int'(vecs[k].ird));
        end

        // Narrow register range keeps hazards, saturation and bypass collisions frequent.
        for (int k = 0; k < 600; k++) begin
            logic     rst, wen, iv;
            int       ws, r1, r2, ird;
            word_t    wd;
            word_t    e1, e2;
            logic     b1, b2, rdy;
            rst = ($urandom_range(0, 59) == 0);
            wen = ($urandom_range(0, 2) == 0);
            iv  = ($urandom_range(0, 1) == 0);
            ws  = $urandom_range(0, 5);
            r1  = $urandom_range(0, 5);
            r2  = $urandom_range(0, 5);
            ird = $urandom_range(0, 5);
            wd  = $urandom;
            drive(rst, wen, regbits_t'(ws), wd, regbits_t'(r1), regbits_t'(r2), iv, regbits_t'(ird));

            rdy = !(iv && ird != 0 && model_pend[ird] == 3);
            e1 = (r1 == 0) ? 32'h0 : (wen && ws == r1) ? wd : word_t'(model_regs[r1]);
            e2 = (r2 == 0) ? 32'h0 : (wen && ws == r2) ? wd : word_t'(model_regs[r2]);
            b1 = (r1 != 0) && (model_pend[r1] - ((wen && ws == r1 && model_pend[r1] > 0) ? 1 : 0)) > 0;
            b2 = (r2 != 0) && (model_pend[r2] - ((wen && ws == r2 && model_pend[r2] > 0) ? 1 : 0)) > 0;
            #3;
            check("rnd_rdat1", k, rdat1, e1);
            check("rnd_rdat2", k, rdat2, e2);
            check("rnd_busy1", k, 32'(busy1), 32'(b1));
            check("rnd_busy2", k, 32'(busy2), 32'(b2));
            check("rnd_issue_ready", k, 32'(issue_ready), 32'(rdy));
            tick(rst, wen, ws, wd, iv, ird);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
